// File: rtl/dm_port_arbiter.sv
// Shares one synchronous data-memory port between the CPU MEM stage and the PDU debug port.
// Each access runs arbitrate/access/respond. Optional grant/fault counters are enabled by `DM_ARB_STATS_EN.
module dm_port_arbiter #(
    parameter int unsigned AW       = 8,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [31:0]   cpu_addr,
    input  logic [31:0]   cpu_wdata,
    output logic          cpu_ack,
    output logic [31:0]   cpu_rdata,
    output logic          cpu_err,
    input  logic          pdu_req,
    input  logic          pdu_we,
    input  logic [31:0]   pdu_addr,
    input  logic [31:0]   pdu_wdata,
    output logic          pdu_ack,
    output logic [31:0]   pdu_rdata,
    output logic          pdu_err,
    input  logic          cpu_stop,
    output logic [AW-1:0] dm_a,
    output logic [31:0]   dm_d,
    output logic          dm_we,
    input  logic [31:0]   dm_spo,
    output logic          busy,
    output logic [15:0]   cpu_grants,
    output logic [15:0]   pdu_grants,
    output logic [15:0]   fault_cnt
);

    localparam int unsigned WCW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            win_pdu_q, win_pdu_d;
    logic            we_q, we_d;
    logic            fault_q, fault_d;
    logic [AW-1:0]   dm_a_q, dm_a_d;
    logic [31:0]     dm_d_q, dm_d_d;
    logic            dm_we_q, dm_we_d;
    logic            busy_q, busy_d;
    logic [WCW-1:0]  wait_cnt_q, wait_cnt_d;
    logic            cpu_ack_q, cpu_ack_d;
    logic            pdu_ack_q, pdu_ack_d;
    logic            cpu_err_q, cpu_err_d;
    logic            pdu_err_q, pdu_err_d;
    logic [31:0]     cpu_rdata_q, cpu_rdata_d;
    logic [31:0]     pdu_rdata_q, pdu_rdata_d;

    logic            pick_pdu_c;
    logic            sel_we_c;
    logic [31:0]     sel_addr_c;
    logic [31:0]     sel_wdata_c;
    logic            sel_fault_c;
    logic [31:0]     resp_data_c;

    // Winner selection and fault decode of the request presented in IDLE
    always_comb begin
        pick_pdu_c  = pdu_req && (cpu_stop || (wait_cnt_q == WCW'(MAX_WAIT)) || !cpu_req);
        sel_we_c    = pick_pdu_c ? pdu_we    : cpu_we;
        sel_addr_c  = pick_pdu_c ? pdu_addr  : cpu_addr;
        sel_wdata_c = pick_pdu_c ? pdu_wdata : cpu_wdata;
        sel_fault_c = (sel_addr_c[1:0] != 2'b00) || (sel_addr_c[31:AW+2] != '0);
        resp_data_c = (fault_q || we_q) ? 32'h0 : dm_spo;
    end

    always_comb begin
        state_d     = state_q;
        win_pdu_d   = win_pdu_q;
        we_d        = we_q;
        fault_d     = fault_q;
        dm_a_d      = dm_a_q;
        dm_d_d      = dm_d_q;
        dm_we_d     = 1'b0;
        wait_cnt_d  = wait_cnt_q;
        cpu_ack_d   = 1'b0;
        pdu_ack_d   = 1'b0;
        cpu_err_d   = cpu_err_q;
        pdu_err_d   = pdu_err_q;
        cpu_rdata_d = cpu_rdata_q;
        pdu_rdata_d = pdu_rdata_q;
        case (state_q)
            IDLE: begin
                if (pdu_req && pick_pdu_c) begin
                    wait_cnt_d = '0;
                end else if (pdu_req && (wait_cnt_q != WCW'(MAX_WAIT))) begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end
                if (cpu_req || pdu_req) begin
                    state_d   = ACCESS;
                    win_pdu_d = pick_pdu_c;
                    we_d      = sel_we_c;
                    fault_d   = sel_fault_c;
                    dm_a_d    = sel_addr_c[AW+1:2];
                    dm_d_d    = sel_wdata_c;
                    dm_we_d   = sel_we_c && !sel_fault_c;
                end
            end
            ACCESS: begin
                state_d = RESP;
                if (win_pdu_q) begin
                    pdu_ack_d = 1'b1;
                    pdu_err_d = fault_q;
                end else begin
                    cpu_ack_d = 1'b1;
                    cpu_err_d = fault_q;
                end
            end
            RESP: begin
                state_d = IDLE;
                if (win_pdu_q) begin
                    pdu_rdata_d = resp_data_c;
                end else begin
                    cpu_rdata_d = resp_data_c;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            win_pdu_q   <= 1'b0;
            we_q        <= 1'b0;
            fault_q     <= 1'b0;
            dm_a_q      <= '0;
            dm_d_q      <= '0;
            dm_we_q     <= 1'b0;
            busy_q      <= 1'b0;
            wait_cnt_q  <= '0;
            cpu_ack_q   <= 1'b0;
            pdu_ack_q   <= 1'b0;
            cpu_err_q   <= 1'b0;
            pdu_err_q   <= 1'b0;
            cpu_rdata_q <= '0;
            pdu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            win_pdu_q   <= win_pdu_d;
            we_q        <= we_d;
            fault_q     <= fault_d;
            dm_a_q      <= dm_a_d;
            dm_d_q      <= dm_d_d;
            dm_we_q     <= dm_we_d;
            busy_q      <= busy_d;
            wait_cnt_q  <= wait_cnt_d;
            cpu_ack_q   <= cpu_ack_d;
            pdu_ack_q   <= pdu_ack_d;
            cpu_err_q   <= cpu_err_d;
            pdu_err_q   <= pdu_err_d;
            cpu_rdata_q <= cpu_rdata_d;
            pdu_rdata_q <= pdu_rdata_d;
        end
    end

    // Memory read data is only valid during RESP, so it is passed straight through then and held afterwards
    assign cpu_rdata = cpu_ack_q ? resp_data_c : cpu_rdata_q;
    assign pdu_rdata = pdu_ack_q ? resp_data_c : pdu_rdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign pdu_ack   = pdu_ack_q;
    assign cpu_err   = cpu_err_q;
    assign pdu_err   = pdu_err_q;
    assign dm_a      = dm_a_q;
    assign dm_d      = dm_d_q;
    assign dm_we     = dm_we_q;
    assign busy      = busy_q;

`ifdef DM_ARB_STATS_EN
    logic [15:0] cpu_grants_q, cpu_grants_d;
    logic [15:0] pdu_grants_q, pdu_grants_d;
    logic [15:0] fault_cnt_q, fault_cnt_d;

    // Saturating counters, one step per ack cycle
    always_comb begin
        cpu_grants_d = cpu_grants_q;
        pdu_grants_d = pdu_grants_q;
        fault_cnt_d  = fault_cnt_q;
        if (cpu_ack_q && (cpu_grants_q != 16'hFFFF)) begin
            cpu_grants_d = cpu_grants_q + 16'd1;
        end
        if (pdu_ack_q && (pdu_grants_q != 16'hFFFF)) begin
            pdu_grants_d = pdu_grants_q + 16'd1;
        end
        if (((cpu_ack_q && cpu_err_q) || (pdu_ack_q && pdu_err_q)) && (fault_cnt_q != 16'hFFFF)) begin
            fault_cnt_d = fault_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cpu_grants_q <= '0;
            pdu_grants_q <= '0;
            fault_cnt_q  <= '0;
        end else begin
            cpu_grants_q <= cpu_grants_d;
            pdu_grants_q <= pdu_grants_d;
            fault_cnt_q  <= fault_cnt_d;
        end
    end

    assign cpu_grants = cpu_grants_q;
    assign pdu_grants = pdu_grants_q;
    assign fault_cnt  = fault_cnt_q;
`else
    assign cpu_grants = 16'h0;
    assign pdu_grants = 16'h0;
    assign fault_cnt  = 16'h0;
`endif

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a synchronous memory model behind the dm_* port.
module tb_dm_port_arbiter;

    localparam int unsigned AW = 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic          cpu_req, cpu_we, pdu_req, pdu_we, cpu_stop;
    logic [31:0]   cpu_addr, cpu_wdata, pdu_addr, pdu_wdata;
    logic          cpu_ack, cpu_err, pdu_ack, pdu_err, dm_we, busy;
    logic [31:0]   cpu_rdata, pdu_rdata, dm_d, dm_spo;
    logic [AW-1:0] dm_a;
    logic [15:0]   cpu_grants, pdu_grants, fault_cnt;

    logic          pre_en;
    logic [AW-1:0] pre_a;
    logic [31:0]   pre_d;
    logic [31:0]   mem [256];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dm_port_arbiter #(.AW(AW), .MAX_WAIT(8)) dut (
        .clk(clk), .rstn(rstn),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .pdu_req(pdu_req), .pdu_we(pdu_we), .pdu_addr(pdu_addr), .pdu_wdata(pdu_wdata),
        .pdu_ack(pdu_ack), .pdu_rdata(pdu_rdata), .pdu_err(pdu_err),
        .cpu_stop(cpu_stop),
        .dm_a(dm_a), .dm_d(dm_d), .dm_we(dm_we), .dm_spo(dm_spo),
        .busy(busy),
        .cpu_grants(cpu_grants), .pdu_grants(pdu_grants), .fault_cnt(fault_cnt)
    );

    // Synchronous single-port memory with a bench-side preload port
    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_a] <= pre_d;
        end else if (dm_we) begin
            mem[dm_a] <= dm_d;
        end
        dm_spo <= mem[dm_a];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
        pre_en = 1'b1;
        pre_a  = a;
        pre_d  = d;
        tick();
        pre_en = 1'b0;
    endtask

    // Presents a CPU request in the current IDLE cycle; returns in the RESP cycle
    task automatic cpu_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        tick();
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        pdu_req = 1'b0; pdu_we = 1'b0; pdu_addr = '0; pdu_wdata = '0;
        cpu_stop = 1'b0;
        pre_en = 1'b0; pre_a = '0; pre_d = '0;
        tick();
        preload(8'd0, 32'h0);
        preload(8'd4, 32'hDEADBEEF);
        preload(8'd8, 32'h0);
        preload(8'd12, 32'h11111111);

        check("rst_busy", 32'(busy), 32'h0);
        check("rst_cpu_ack", 32'(cpu_ack), 32'h0);
        check("rst_cpu_rdata", cpu_rdata, 32'h0);
        check("rst_pdu_rdata", pdu_rdata, 32'h0);
        check("rst_dm_we", 32'(dm_we), 32'h0);
        check("rst_wait_cnt", 32'(dut.wait_cnt_q), 32'h0);
        rstn = 1'b1;
        tick();

        // CPU read of 0x10
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        check("rd_idle_busy", 32'(busy), 32'h0);
        tick();
        cpu_req = 1'b0;
        check("rd_access_busy", 32'(busy), 32'h1);
        check("rd_access_dm_a", 32'(dm_a), 32'h4);
        check("rd_access_dm_we", 32'(dm_we), 32'h0);
        check("rd_access_ack", 32'(cpu_ack), 32'h0);
        tick();
        check("rd_resp_ack", 32'(cpu_ack), 32'h1);
        check("rd_resp_rdata", cpu_rdata, 32'hDEADBEEF);
        check("rd_resp_err", 32'(cpu_err), 32'h0);
        check("rd_resp_busy", 32'(busy), 32'h1);
        tick();
        check("rd_after_ack", 32'(cpu_ack), 32'h0);
        check("rd_after_rdata", cpu_rdata, 32'hDEADBEEF);
        check("rd_after_busy", 32'(busy), 32'h0);

        // CPU write 0x20 then read back
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h12345678;
        tick();
        cpu_req = 1'b0; cpu_we = 1'b0;
        check("wr_dm_we", 32'(dm_we), 32'h1);
        check("wr_dm_a", 32'(dm_a), 32'h8);
        check("wr_dm_d", dm_d, 32'h12345678);
        tick();
        check("wr_dm_we_drop", 32'(dm_we), 32'h0);
        check("wr_ack", 32'(cpu_ack), 32'h1);
        check("wr_rdata", cpu_rdata, 32'h0);
        tick();
        cpu_access(1'b0, 32'h20, 32'h0);
        check("wr_readback", cpu_rdata, 32'h12345678);
        tick();

        // Simultaneous requests, CPU running: CPU first, PDU three cycles later
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        pdu_req = 1'b1; pdu_we = 1'b0; pdu_addr = 32'h20;
        tick();
        cpu_req = 1'b0;
        check("sim_cpu_dm_a", 32'(dm_a), 32'h4);
        tick();
        check("sim_cpu_ack", 32'(cpu_ack), 32'h1);
        check("sim_cpu_pdu_ack", 32'(pdu_ack), 32'h0);
        check("sim_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
        tick();
        check("sim_wait_cnt", 32'(dut.wait_cnt_q), 32'h1);
        tick();
        pdu_req = 1'b0;
        check("sim_pdu_dm_a", 32'(dm_a), 32'h8);
        tick();
        check("sim_pdu_ack", 32'(pdu_ack), 32'h1);
        check("sim_pdu_cpu_ack", 32'(cpu_ack), 32'h0);
        check("sim_pdu_rdata", pdu_rdata, 32'h12345678);
        tick();
        check("sim_wait_clr", 32'(dut.wait_cnt_q), 32'h0);

        // Simultaneous requests with CPU clock stopped: PDU first
        cpu_stop = 1'b1;
        cpu_req = 1'b1; cpu_addr = 32'h20;
        pdu_req = 1'b1; pdu_addr = 32'h10;
        tick();
        pdu_req = 1'b0;
        check("stop_pdu_dm_a", 32'(dm_a), 32'h4);
        tick();
        check("stop_pdu_ack", 32'(pdu_ack), 32'h1);
        check("stop_pdu_cpu_ack", 32'(cpu_ack), 32'h0);
        check("stop_pdu_rdata", pdu_rdata, 32'hDEADBEEF);
        tick();
        tick();
        cpu_req = 1'b0;
        tick();
        check("stop_cpu_ack", 32'(cpu_ack), 32'h1);
        check("stop_cpu_rdata", cpu_rdata, 32'h12345678);
        tick();
        cpu_stop = 1'b0;

        // Starvation guard: CPU held continuously, PDU wins after eight pass-overs
        cpu_req = 1'b1; cpu_addr = 32'h10;
        pdu_req = 1'b1; pdu_addr = 32'h20;
        for (int g = 0; g < 8; g++) begin
            tick();
            tick();
            check("starve_cpu_ack", 32'(cpu_ack), 32'h1);
            check("starve_pdu_ack", 32'(pdu_ack), 32'h0);
            tick();
        end
        check("starve_wait_max", 32'(dut.wait_cnt_q), 32'h8);
        tick();
        cpu_req = 1'b0; pdu_req = 1'b0;
        check("starve_wait_clr", 32'(dut.wait_cnt_q), 32'h0);
        check("starve_pdu_dm_a", 32'(dm_a), 32'h8);
        tick();
        check("starve_pdu_win", 32'(pdu_ack), 32'h1);
        check("starve_cpu_idle", 32'(cpu_ack), 32'h0);
        check("starve_pdu_rdata", pdu_rdata, 32'h12345678);
        tick();

        // Misaligned write and out-of-range read
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h402; cpu_wdata = 32'hA5A5A5A5;
        tick();
        cpu_req = 1'b0; cpu_we = 1'b0;
        check("mis_dm_we", 32'(dm_we), 32'h0);
        tick();
        check("mis_dm_we_resp", 32'(dm_we), 32'h0);
        check("mis_ack", 32'(cpu_ack), 32'h1);
        check("mis_err", 32'(cpu_err), 32'h1);
        check("mis_rdata", cpu_rdata, 32'h0);
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h400;
        tick();
        cpu_req = 1'b0;
        check("oor_dm_we", 32'(dm_we), 32'h0);
        tick();
        check("oor_ack", 32'(cpu_ack), 32'h1);
        check("oor_err", 32'(cpu_err), 32'h1);
        check("oor_rdata", cpu_rdata, 32'h0);
        tick();
        check("oor_mem0", mem[0], 32'h0);
        cpu_access(1'b0, 32'h10, 32'h0);
        check("ok_err_clear", 32'(cpu_err), 32'h0);
        check("ok_rdata", cpu_rdata, 32'hDEADBEEF);
        tick();

`ifdef DM_ARB_STATS_EN
        check("stat_cpu", 32'(cpu_grants), 32'd16);
        check("stat_pdu", 32'(pdu_grants), 32'd3);
        check("stat_fault", 32'(fault_cnt), 32'd2);
`else
        check("stat_cpu_off", 32'(cpu_grants), 32'd0);
        check("stat_pdu_off", 32'(pdu_grants), 32'd0);
        check("stat_fault_off", 32'(fault_cnt), 32'd0);
`endif

        // Reset asserted during the ACCESS cycle of a write
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h30; cpu_wdata = 32'hCAFEF00D;
        tick();
        cpu_req = 1'b0; cpu_we = 1'b0;
        check("rstw_dm_we", 32'(dm_we), 32'h1);
        #2;
        rstn = 1'b0;
        #1;
        check("rstw_dm_we_drop", 32'(dm_we), 32'h0);
        check("rstw_busy", 32'(busy), 32'h0);
        check("rstw_rdata", cpu_rdata, 32'h0);
        tick();
        check("rstw_no_ack", 32'(cpu_ack), 32'h0);
        rstn = 1'b1;
        tick();
        check("rstw_no_ack2", 32'(cpu_ack), 32'h0);
        check("rstw_idle", 32'(busy), 32'h0);
        check("rstw_mem", mem[12], 32'h11111111);
        cpu_access(1'b0, 32'h30, 32'h0);
        check("rstw_readback", cpu_rdata, 32'h11111111);
        tick();

`ifdef DM_ARB_STATS_EN
        check("stat_cpu_post", 32'(cpu_grants), 32'd1);
        check("stat_fault_post", 32'(fault_cnt), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
